blake2_msg_mgr: RTL

//  Byte-stream front/back end for a BLAKE2s/BLAKE2b compression core. Packs input bytes into
//  16-word message blocks, tracks byte counter t and last-block flag f, and issues blocks over a

---
 rtl/blake2_msg_mgr_pkg.sv | 43 ++++
 rtl/blake2_msg_mgr_if.sv | 38 +++
 rtl/blake2_msg_mgr_digest_ser.sv | 45 ++++
 rtl/blake2_msg_mgr.sv | 131 +++++++++++++
 4 files changed

// File: rtl/blake2_msg_mgr_pkg.sv
// Shared BLAKE2 definitions: FSM states, block geometry, IVs.
// Word width selects BLAKE2s (32) or BLAKE2b (64).
package blake2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HOLD,
    ISSUE,
    WAIT_H,
    DRAIN
  } state_t;

  localparam int W_S = 32;
  localparam int W_B = 64;

  localparam logic [255:0] IV_S = {
    32'h5BE0CD19, 32'h1F83D9AB,
    32'h9B05688C, 32'h510E527F,
    32'hA54FF53A, 32'h3C6EF372,
    32'hBB67AE85, 32'h6A09E667
  };

  localparam logic [511:0] IV_B = {
    64'h5BE0CD19137E2179,
    64'h1F83D9ABFB41BD6B,
    64'h9B05688C2B3E6C1F,
    64'h510E527FADE682D1,
    64'hA54FF53A5F1D36F1,
    64'h3C6EF372FE94F82B,
    64'hBB67AE8584CAA73B,
    64'h6A09E667F3BCC908
  };

  function automatic int block_bytes(int w);
    return 2 * w;
  endfunction

  function automatic bit w_legal(int w);
    return (w == W_S) || (w == W_B);
  endfunction

endpackage

// File: rtl/blake2_msg_mgr_if.sv
// Byte-in / block-out / digest-out bundle of the message manager.
// slave = manager side, master = byte source, core and sink.
interface blake2_msg_mgr_if #(
  parameter int W = 32
);
  logic              start;
  logic [7:0]        din;
  logic              din_valid;
  logic              din_ready;
  logic              finish;
  logic              blk_valid;
  logic              blk_ready;
  logic [16*W-1:0]   m_out;
  logic [2*W-1:0]    t_out;
  logic              f_out;
  logic [8*W-1:0]    h_in;
  logic              h_valid;
  logic [7:0]        dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;

  modport slave (
    input  start, din, din_valid, finish,
    input  blk_ready, h_in, h_valid, dout_ready,
    output din_ready, blk_valid, m_out, t_out,
    output f_out, dout, dout_valid, dout_last, busy
  );

  modport master (
    output start, din, din_valid, finish,
    output blk_ready, h_in, h_valid, dout_ready,
    input  din_ready, blk_valid, m_out, t_out,
    input  f_out, dout, dout_valid, dout_last, busy
  );

endinterface

// File: rtl/blake2_msg_mgr_digest_ser.sv
// Digest serializer: holds the chaining value and
// shifts out OUT_BYTES bytes, LSB first, under backpressure.
module blake2_digest_ser #(
  parameter int W         = 32,
  parameter int OUT_BYTES = W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           load,
  input  logic [8*W-1:0] h_in,
  input  logic           dout_ready,
  output logic [7:0]     dout,
  output logic           dout_valid,
  output logic           dout_last,
  output logic           done
);

  localparam int OW = $clog2(W + 1);

  logic [8*W-1:0] h;
  logic [OW-1:0]  ocnt;

  assign dout       = h[7:0];
  assign dout_valid = (ocnt != '0);
  assign dout_last  = (ocnt == OW'(1));
  assign done       = dout_valid && dout_ready && dout_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h    <= '0;
      ocnt <= '0;
    end else if (clr) begin
      h    <= '0;
      ocnt <= '0;
    end else if (load) begin
      h    <= h_in;
      ocnt <= OW'(OUT_BYTES);
    end else if (dout_valid && dout_ready) begin
      h    <= h >> 8;
      ocnt <= ocnt - OW'(1);
    end
  end

endmodule

// File: rtl/blake2_msg_mgr.sv
// BLAKE2 message manager: packs bytes into blocks with t/f,
// hands them to the core, then streams the truncated digest.
module blake2_msg_mgr
  import blake2_pkg::*;
#(
  parameter int W         = 32,
  parameter int OUT_BYTES = W
) (
  input logic            clk,
  input logic            rst_n,
  blake2_msg_mgr_if.slave bus
);

  localparam int BB = block_bytes(W);
  localparam int CW = $clog2(BB) + 1;
  localparam logic [CW-1:0]  C_ONE  = CW'(1);
  localparam logic [CW-1:0]  C_LAST = CW'(BB - 1);
  localparam logic [2*W-1:0] T_ONE  = (2*W)'(1);

  state_t          state;
  logic [16*W-1:0] m;
  logic [2*W-1:0]  t;
  logic            f;
  logic [CW-1:0]   cnt;
  logic [7:0]      skid;
  logic            skid_full;
  logic            fin_pend;
  logic            acc;
  logic            h_load;
  logic            drained;

  // no new bytes once a latched finish is waiting
  assign bus.din_ready = (state == FILL && !fin_pend) ||
                         (state == HOLD && !skid_full);
  assign acc           = bus.din_valid && bus.din_ready;
  assign h_load        = (state == WAIT_H) && bus.h_valid && !bus.start;
  assign bus.blk_valid = (state == ISSUE);
  assign bus.m_out     = m;
  assign bus.t_out     = t;
  assign bus.f_out     = f;
  assign bus.busy      = (state != IDLE);

  blake2_digest_ser #(
    .W         (W),
    .OUT_BYTES (OUT_BYTES)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (bus.start),
    .load       (h_load),
    .h_in       (bus.h_in),
    .dout_ready (bus.dout_ready),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .dout_last  (bus.dout_last),
    .done       (drained)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m         <= '0;
      t         <= '0;
      f         <= 1'b0;
      cnt       <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
      fin_pend  <= 1'b0;
    end else if (bus.start) begin
      state     <= FILL;
      m         <= '0;
      t         <= '0;
      f         <= 1'b0;
      cnt       <= '0;
      skid      <= '0;
      skid_full <= 1'b0;
      fin_pend  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        FILL: begin
          if (acc) begin
            m[8*int'(cnt) +: 8] <= bus.din;
            cnt <= cnt + C_ONE;
            t   <= t + T_ONE;
          end
          if (bus.finish || fin_pend) begin
            f        <= 1'b1;
            fin_pend <= 1'b0;
            state    <= ISSUE;
          end else if (acc && cnt == C_LAST) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // a byte here proves the full block is not final
          if (acc) begin
            skid      <= bus.din;
            skid_full <= 1'b1;
            fin_pend  <= bus.finish;
            state     <= ISSUE;
          end else if (bus.finish) begin
            f     <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.blk_ready) begin
            m         <= '0;
            cnt       <= '0;
            skid_full <= 1'b0;
            if (skid_full) begin
              m[7:0] <= skid;
              cnt    <= C_ONE;
              t      <= t + T_ONE;
            end
            state <= f ? WAIT_H : FILL;
          end
        end
        WAIT_H: begin
          if (bus.h_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (drained) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
